// File: rtl/io_map_pkg.sv
// -----------------------------------------------------------------------------
// io_map_pkg
// Shared definitions for the memory-mapped I/O bridge:
//   - IO region prefix and register offsets inside the 4 KB IO page
//   - IO register selector enum and the offset decoder
//   - active-low seven-segment codes, bit order {DP,G,F,E,D,C,B,A}
// -----------------------------------------------------------------------------
package io_map_pkg;

    // cpu_addr[31:12] equal to this prefix selects the IO page.
    localparam logic [19:0] IO_BASE   = 20'hFFFFF;

    localparam logic [11:0] OFF_SEG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;

    localparam int LED_W = 24;
    localparam int SW_W  = 24;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_SEG,
        REG_TIMER,
        REG_LED,
        REG_SW
    } io_reg_e;

    // Hex digit to segment pattern, DP off (bit 7 high).
    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Only exact word offsets match; unaligned or unlisted offsets map to REG_NONE.
    function automatic io_reg_e io_decode(input logic [11:0] offset);
        case (offset)
            OFF_SEG:   return REG_SEG;
            OFF_TIMER: return REG_TIMER;
            OFF_LED:   return REG_LED;
            OFF_SW:    return REG_SW;
            default:   return REG_NONE;
        endcase
    endfunction

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Multiplexed 8-digit seven-segment driver. A prescaler holds each digit lit
// for SCAN_DIV cycles, then advances the digit index 0..7 (wrapping).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   seg_value_i    32-bit display value, nibble i shown on digit i
//   seg_en_o       digit enables, active-low, registered
//   seg_code_o     segment pattern, active-low, registered
// -----------------------------------------------------------------------------
module seg_scan #(
    parameter int SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_value_i,
    output logic [7:0]  seg_en_o,
    output logic [7:0]  seg_code_o
);
    import io_map_pkg::*;

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       dig_q, dig_d;
    logic [7:0]       seg_en_q, seg_en_d;
    logic [7:0]       seg_code_q, seg_code_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        scan_cnt_d = scan_cnt_q + CNT_W'(1);
        dig_d      = dig_q;
        if (scan_cnt_q == CNT_LAST) begin
            scan_cnt_d = '0;
            dig_d      = dig_q + 3'd1;
        end
        // Enable and code are both derived from the next digit index, so they
        // load on the same edge and never show a digit with another's code.
        seg_en_d   = ~(8'b1 << dig_d);
        seg_code_d = hex_to_seg(seg_value_i[{dig_d, 2'b00} +: 4]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample their next-state values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            dig_q      <= '0;
            seg_en_q   <= 8'hFE;
            seg_code_q <= hex_to_seg(4'h0);
        end else begin
            scan_cnt_q <= scan_cnt_d;
            dig_q      <= dig_d;
            seg_en_q   <= seg_en_d;
            seg_code_q <= seg_code_d;
        end
    end

    assign seg_en_o   = seg_en_q;
    assign seg_code_o = seg_code_q;

endmodule

// File: rtl/io_bus_bridge.sv
// -----------------------------------------------------------------------------
// io_bus_bridge
// Data-path bridge between the single-cycle CPU and data_mem. Addresses in the
// IO page (cpu_addr[31:12] == 20'hFFFFF) hit the peripheral registers; all
// other addresses go to the RAM. Load data returns combinationally.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_addr/we/wdata/rdata  CPU data access (byte address, store, load data)
//   dram_addr/we/wdata/rdata data_mem side (word address, gated store, data)
//   sw                       board switches, asynchronous, synchronised here
//   led                      LED drive, active-high
//   seg_en, seg_code         multiplexed seven-segment display, active-low
// IO registers: SEG 0x000 RW, TIMER 0x020 RW, LED 0x060 RW, SW 0x070 RO.
// -----------------------------------------------------------------------------
module io_bus_bridge #(
    parameter int SCAN_DIV = 20000,
    parameter int DRAM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        cpu_addr,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [7:0]         seg_en,
    output logic [7:0]         seg_code
);
    import io_map_pkg::*;

    logic              io_hit;
    io_reg_e           io_sel;
    logic [31:0]       io_rdata;

    logic [31:0]       seg_q, seg_d;
    logic [31:0]       timer_q, timer_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

    // ---- address decode and RAM routing ----
    assign io_hit     = (cpu_addr[31:12] == IO_BASE);
    assign io_sel     = io_hit ? io_decode(cpu_addr[11:0]) : REG_NONE;

    assign dram_addr  = cpu_addr[DRAM_AW+1:2];
    assign dram_wdata = cpu_wdata;
    assign dram_we    = cpu_we & ~io_hit;

    // ---- IO register next state ----
    // A store to TIMER overrides that cycle's increment.
    always_comb begin
        seg_d   = seg_q;
        led_d   = led_q;
        timer_d = timer_q + 32'd1;
        if (cpu_we) begin
            case (io_sel)
                REG_SEG:   seg_d   = cpu_wdata;
                REG_TIMER: timer_d = cpu_wdata;
                REG_LED:   led_d   = cpu_wdata[LED_W-1:0];
                default:   ;
            endcase
        end
    end

    // sw is asynchronous to clk; sw_meta_q may go metastable and is only ever
    // consumed through sw_sync_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q     <= '0;
            timer_q   <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            seg_q     <= seg_d;
            timer_q   <= timer_d;
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // ---- read mux ----
    always_comb begin
        io_rdata = '0;
        case (io_sel)
            REG_SEG:   io_rdata = seg_q;
            REG_TIMER: io_rdata = timer_q;
            REG_LED:   io_rdata = {{(32-LED_W){1'b0}}, led_q};
            REG_SW:    io_rdata = {{(32-SW_W){1'b0}}, sw_sync_q};
            default:   io_rdata = '0;
        endcase
        cpu_rdata = io_hit ? io_rdata : dram_rdata;
    end

    assign led = led_q;

    // ---- display ----
    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk         (clk),
        .rst         (rst),
        .seg_value_i (seg_q),
        .seg_en_o    (seg_en),
        .seg_code_o  (seg_code)
    );

endmodule

// File: tb/tb_io_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_io_bus_bridge
// Scoreboard bench for io_bus_bridge. The driver applies one CPU access per
// cycle, computes the expected outputs for that cycle from a reference model
// (edge count since reset, write history, switch history) and queues them; a
// monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_io_bus_bridge;

    localparam int SCAN_DIV = 4;
    localparam int DRAM_AW  = 14;

    localparam logic [7:0] HEX7 [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        cpu_addr = '0;
    logic               cpu_we = 1'b0;
    logic [31:0]        cpu_wdata = '0;
    logic [31:0]        cpu_rdata;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_we;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata = '0;
    logic [23:0]        sw = '0;
    logic [23:0]        led;
    logic [7:0]         seg_en;
    logic [7:0]         seg_code;

    always #5 clk = ~clk;

    io_bus_bridge #(
        .SCAN_DIV (SCAN_DIV),
        .DRAM_AW  (DRAM_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .seg_en     (seg_en),
        .seg_code   (seg_code)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        dram_we;
        logic [31:0] dram_addr;
        logic [31:0] dram_wdata;
        logic [23:0] led;
        logic [7:0]  seg_en;
        logic [7:0]  seg_code;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // ---- reference model state: values visible after n_model edges ----
    int          n_model;
    logic [31:0] m_seg;
    logic [31:0] m_seg_prev;     // SEG as it was one edge earlier
    logic [23:0] m_led;
    logic [31:0] t_base_val;     // timer = t_base_val + (n_model - t_base_n)
    int          t_base_n;
    logic [23:0] sw_hist [int];  // sw driven in the cycle after k edges
    logic [23:0] sw_next = '0;
    int          cyc_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_timer();
        return t_base_val + 32'(n_model - t_base_n);
    endfunction

    function automatic logic [23:0] m_sw_sync();
        if (n_model < 2 || !sw_hist.exists(n_model - 2))
            return 24'h0;
        return sw_hist[n_model - 2];
    endfunction

    // Drive one cycle of inputs, queue the expected outputs, advance the model.
    task automatic apply(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [23:0] swv);
        exp_t        e;
        logic        io;
        int          d;
        logic [31:0] rd;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        sw         = swv;
        dram_rdata = $urandom();
        if (rst) begin
            n_model    = 0;
            m_seg      = '0;
            m_seg_prev = '0;
            m_led      = '0;
            t_base_val = '0;
            t_base_n   = 0;
            sw_hist.delete();
        end
        io = (addr[31:12] == 20'hFFFFF);
        rd = dram_rdata;
        if (io) begin
            case (addr[11:0])
                12'h000: rd = m_seg;
                12'h020: rd = m_timer();
                12'h060: rd = {8'h00, m_led};
                12'h070: rd = {8'h00, m_sw_sync()};
                default: rd = 32'h0;
            endcase
        end
        d            = (n_model / SCAN_DIV) % 8;
        e.cyc        = cyc_no;
        e.rdata      = rd;
        e.dram_we    = we & ~io;
        e.dram_addr  = 32'(addr[DRAM_AW+1:2]);
        e.dram_wdata = wdata;
        e.led        = m_led;
        e.seg_en     = ~(8'h01 << d);
        e.seg_code   = HEX7[4'(m_seg_prev >> (4 * d))];
        exp_q.push_back(e);
        cyc_no++;
        if (!rst) begin
            sw_hist[n_model] = swv;
            m_seg_prev       = m_seg;
            if (we && io) begin
                case (addr[11:0])
                    12'h000: m_seg = wdata;
                    12'h020: begin t_base_val = wdata; t_base_n = n_model + 1; end
                    12'h060: m_led = wdata[23:0];
                    default: ;
                endcase
            end
            n_model++;
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        apply(we, addr, wdata, sw_next);
    endtask

    // One cycle of reset (optionally with a store that must be lost), then release.
    task automatic do_reset(input logic with_store);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(with_store, 32'hFFFFF060, $urandom(), 24'($urandom()));
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1'b0, 32'hFFFFF060, 32'h0, sw_next);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFFF000;
            1:       return 32'hFFFFF020;
            2:       return 32'hFFFFF060;
            3:       return 32'hFFFFF070;
            4:       return {20'hFFFFF, a[11:0]};
            5:       return 32'hFFFFF060 + 32'($urandom_range(1, 3));
            default: return a;
        endcase
    endfunction

    // ---- monitor ----
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("c%0d rdata", mon_e.cyc),      cpu_rdata,          mon_e.rdata);
            check($sformatf("c%0d dram_we", mon_e.cyc),    32'(dram_we),       32'(mon_e.dram_we));
            check($sformatf("c%0d dram_addr", mon_e.cyc),  32'(dram_addr),     mon_e.dram_addr);
            check($sformatf("c%0d dram_wdata", mon_e.cyc), dram_wdata,         mon_e.dram_wdata);
            check($sformatf("c%0d led", mon_e.cyc),        32'(led),           32'(mon_e.led));
            check($sformatf("c%0d seg_en", mon_e.cyc),     32'(seg_en),        32'(mon_e.seg_en));
            check($sformatf("c%0d seg_code", mon_e.cyc),   32'(seg_code),      32'(mon_e.seg_code));
        end
    end

    // ---- stimulus ----
    initial begin
        do_reset(1'b0);

        // RAM routing
        drive(1'b1, 32'h00000010, 32'h12345678);
        // LED write then read back
        drive(1'b1, 32'hFFFFF060, 32'hFFABCDEF);
        drive(1'b0, 32'hFFFFF060, 32'h0);
        // timer: read, store near wrap, then watch it wrap
        drive(1'b0, 32'hFFFFF020, 32'h0);
        drive(1'b1, 32'hFFFFF020, 32'hFFFFFFFE);
        repeat (4) drive(1'b0, 32'hFFFFF020, 32'h0);
        // switch synchroniser and read-only behaviour
        sw_next = 24'h00A5A5;
        repeat (4) drive(1'b0, 32'hFFFFF070, 32'h0);
        drive(1'b1, 32'hFFFFF070, 32'hDEADBEEF);
        drive(1'b0, 32'hFFFFF070, 32'h0);
        // display walk across all eight digits
        drive(1'b1, 32'hFFFFF000, 32'h76543210);
        repeat (40) drive(1'b0, 32'hFFFFF000, 32'h0);
        // unmapped IO offset
        drive(1'b1, 32'hFFFFF100, 32'hCAFEF00D);
        drive(1'b0, 32'hFFFFF100, 32'h0);
        drive(1'b0, 32'hFFFFF060, 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                sw_next = 24'($urandom());
            drive(1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end

        // reset mid-scan with a store in flight, then more traffic
        do_reset(1'b1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                sw_next = 24'($urandom());
            drive(1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end

        // let the monitor drain, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
# io_bus_bridge

Memory-mapped I/O bridge on the single-cycle CPU's data-access path. It sits directly downstream of the ALU result and register-file read port, and in front of `data_mem`. It decodes each load/store address and routes it either to the 64 KB data RAM or to on-board peripherals. The peripherals are an LED register, switch inputs, a free-running cycle timer, and an 8-digit multiplexed seven-segment display. It returns read data to the CPU in the same cycle, which the single-cycle datapath requires.

## Interface
Parameters:
- `SCAN_DIV`, 20000, clock cycles each display digit stays lit before the scan advances; minimum 2.
- `DRAM_AW`, 14, word-address width of `data_mem`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high (one clock; polarity and synchronicity fixed).
- `cpu_addr`  in  32  byte address (ALU result).
- `cpu_we`  in  1  store enable.
- `cpu_wdata`  in  32  store data (rs2).
- `cpu_rdata`  out  32  load data, combinational.
- `dram_addr`  out  DRAM_AW  equals `cpu_addr[DRAM_AW+1:2]`.
- `dram_we`  out  1  store enable gated to the RAM region.
- `dram_wdata`  out  32  equals `cpu_wdata`.
- `dram_rdata`  in  32  asynchronous RAM read data.
- `sw`  in  24  board switches, asynchronous to `clk`.
- `led`  out  24  LED drive, active-high.
- `seg_en`  out  8  digit enables, active-low; bit i selects digit i.
- `seg_code`  out  8  segment pattern, active-low, bit order {DP,G,F,E,D,C,B,A}.

## Operation
- IO region: `cpu_addr[31:12] == 20'hFFFFF`. Any other address is RAM.
- Word-aligned IO registers, selected by `cpu_addr[11:0]`:
  - 0x000 SEG: RW, 32 bits. Nibble i is shown on digit i.
  - 0x020 TIMER: RW, 32 bits, free-running counter.
  - 0x060 LED: RW, bits [23:0]; reads return zero in [31:24].
  - 0x070 SW: RO, bits [23:0] of the synchronised switches; writes ignored.
  - Any other IO offset: reads return 0, writes ignored.
- `dram_we = cpu_we & ~io_hit`. IO stores never reach RAM.
- `cpu_rdata` = `dram_rdata` when not `io_hit`, otherwise the selected IO register value.
- TIMER:
  - Increments by 1 every cycle, wrapping 0xFFFFFFFF -> 0.
  - A store in the same cycle wins: TIMER takes `cpu_wdata` and resumes incrementing on the following edge.
- SW: two-flop synchroniser; reads reflect `sw` sampled two edges earlier.
- Display scan:
  - Counter `scan_cnt` runs 0..SCAN_DIV-1.
  - When `scan_cnt` wraps, digit index `dig` advances 0..7 and wraps 7 -> 0.
  - `seg_en = ~(8'b1 << dig)`.
  - `seg_code` = hex decode of `SEG[4*dig+3:4*dig]`, DP always off (bit 7 = 1).
    - 0 -> 8'hC0, 1 -> 8'hF9, 2 -> 8'hA4, 3 -> 8'hB0, 4 -> 8'h99, 5 -> 8'h92, 6 -> 8'h82, 7 -> 8'hF8
    - 8 -> 8'h80, 9 -> 8'h90, A -> 8'h88, b -> 8'h83, C -> 8'hC6, d -> 8'hA1, E -> 8'h86, F -> 8'h8E
- `seg_en` and `seg_code` are registered outputs, so they are glitch-free.

## Timing
- Reset values (asynchronous, take effect immediately on `rst` assertion):
  - SEG = 0, LED = 0, TIMER = 0.
  - Synchroniser flops = 0.
  - `scan_cnt` = 0, `dig` = 0.
  - `seg_en` = 8'hFE, `seg_code` = 8'hC0, `led` = 0.
- Reads: zero latency, combinational from registered state and `dram_rdata`.
- Writes: committed on the rising edge where `cpu_we` = 1.
  - A load of the same register in the next cycle returns the new value.
  - `led` updates on that same edge.
  - `seg_code` reflects a new SEG value one edge after the write, if that digit is currently lit.
- Scan: `dig` changes every SCAN_DIV cycles. `seg_en` and `seg_code` change on the same edge, with no cycle of mismatched digit and code.
- Reset asserted mid-scan or during a store: all state returns to reset values and the store is lost. The first scan advance occurs SCAN_DIV cycles after `rst` deasserts.

## Structure
- Shared package `io_map_pkg`:
  - IO base prefix 20'hFFFFF.
  - Offsets SEG/TIMER/LED/SW.
  - 16-entry seven-segment code constants.
- One sub-module, `seg_scan`: scan counter, digit index, decoder, output registers.
  - Inputs: `clk`, `rst`, SEG value.
  - Outputs: `seg_en`, `seg_code`.
- The top-level bridge holds the address decode, IO registers, timer, synchroniser and read mux.

## Test plan
- Reset and RAM routing: assert `rst`, check all outputs at reset values. Then store 0x12345678 to 0x00000010 -> `dram_we` = 1, `dram_addr` = 4, `dram_wdata` = 0x12345678.
- LED write/read: store 0xFFABCDEF to 0xFFFFF060 -> `dram_we` = 0, `led` = 24'hABCDEF after the edge; load returns 0x00ABCDEF.
- Timer: after reset, load 0xFFFFF020 at cycle N -> returns N. Store 0xFFFFFFFE, then read on the next two cycles -> 0xFFFFFFFE, then 0xFFFFFFFF. One cycle later the timer has wrapped to 0.
- Switch synchroniser: set `sw` = 24'h00A5A5 -> load of 0xFFFFF070 returns the old value for two edges, then 0x0000A5A5. Store to 0xFFFFF070 has no effect.
- Display scan with SCAN_DIV = 4: write SEG = 0x76543210. Then `seg_en` walks FE, FD, FB, ... 7F, FE every 4 cycles, with `seg_code` C0, F9, A4, B0, 99, 92, 82, F8 in lockstep.
- Unmapped IO: store to 0xFFFFF100 -> no register changes, `dram_we` = 0; load returns 0.
